// File: rtl/y86_pkg.sv
// y86_pkg: shared loader states, memory size default and fetch status codes
package y86_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, ERR} ld_state_e;
  localparam int MEM_BYTES_DEF = 1024;
  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-serial load port plus fetch read port of the instruction memory
interface imem_loader_if #(parameter int PC_W = 64);
  logic            ld_start;
  logic [PC_W-1:0] ld_base;
  logic            ld_valid;
  logic [7:0]      ld_byte;
  logic            ld_last;
  logic            ld_ready;
  logic            ld_done;
  logic            ld_err;
  logic            mem_ready;
  logic [PC_W-1:0] f_pc;
  logic [7:0]      byte0;
  logic [71:0]     byte19;
  logic            imem_error;
  modport master (
    output ld_start, ld_base, ld_valid, ld_byte, ld_last, f_pc,
    input  ld_ready, ld_done, ld_err, mem_ready, byte0, byte19, imem_error
  );
  modport slave (
    input  ld_start, ld_base, ld_valid, ld_byte, ld_last, f_pc,
    output ld_ready, ld_done, ld_err, mem_ready, byte0, byte19, imem_error
  );
endinterface

// File: rtl/imem_array.sv
// imem_array: byte store with one synchronous write port and a ten-byte zero-filled read window
module imem_array #(
  parameter int MEM_BYTES = 1024,
  parameter int PC_W      = 64,
  parameter int AW        = $clog2(MEM_BYTES)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [7:0]      wdata,
  input  logic [PC_W-1:0] raddr,
  output logic [79:0]     rdata
);
  logic [7:0] mem [MEM_BYTES];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  for (genvar i = 0; i < 10; i++) begin : g_rd
    logic [PC_W-1:0] a;
    assign a = raddr + PC_W'(i);
    // a < raddr means the address sum wrapped past the top of the PC space
    assign rdata[8*i +: 8] = (a >= raddr && a < PC_W'(MEM_BYTES)) ? mem[a[AW-1:0]] : 8'h00;
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: Y86-64 instruction memory filled by a ready/valid byte loader, read by fetch
module imem_loader
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF,
  parameter int PC_W      = 64
) (
  input logic         clk,
  input logic         rst_n,
  imem_loader_if.slave bus
);
  localparam int AW = $clog2(MEM_BYTES);
  localparam logic [PC_W-1:0] TOP = PC_W'(MEM_BYTES);
  ld_state_e       state_q, state_d;
  logic [PC_W-1:0] wr_addr_q, wr_addr_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            we;
  logic [79:0]     rdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_addr_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    done_d    = 1'b0;
    err_d     = err_q;
    we        = 1'b0;
    if (bus.ld_start) begin
      state_d   = LOAD;
      wr_addr_d = bus.ld_base;
      err_d     = 1'b0;
    end else if (state_q == LOAD && bus.ld_valid) begin
      if (wr_addr_q < TOP) begin
        we        = 1'b1;
        wr_addr_d = wr_addr_q + 1'b1;
        state_d   = bus.ld_last ? RUN : LOAD;
        done_d    = bus.ld_last;
      end else begin
        state_d = ERR;
        err_d   = 1'b1;
      end
    end
  end
  imem_array #(.MEM_BYTES(MEM_BYTES), .PC_W(PC_W), .AW(AW)) u_array (
    .clk   (clk),
    .we    (we),
    .waddr (wr_addr_q[AW-1:0]),
    .wdata (bus.ld_byte),
    .raddr (bus.f_pc),
    .rdata (rdata)
  );
  assign bus.ld_ready   = state_q == LOAD;
  assign bus.ld_done    = done_q;
  assign bus.ld_err     = err_q;
  assign bus.mem_ready  = state_q == RUN;
  assign bus.byte0      = rdata[7:0];
  assign bus.byte19     = rdata[79:8];
  assign bus.imem_error = state_q != RUN || bus.f_pc >= TOP;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed load/fetch sequence with hand-computed expectations
module tb_imem_loader;
  localparam int MB = 1024;
  logic clk = 1'b0;
  logic rst_n;
  int total = 0;
  int bad = 0;
  imem_loader_if #(.PC_W(64)) bus ();
  imem_loader #(.MEM_BYTES(MB), .PC_W(64)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic start(input logic [63:0] base);
    bus.ld_start = 1'b1;
    bus.ld_base  = base;
    tick();
    bus.ld_start = 1'b0;
  endtask
  task automatic send(input logic [7:0] b, input logic last);
    bus.ld_valid = 1'b1;
    bus.ld_byte  = b;
    bus.ld_last  = last;
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask
  logic [7:0] prog [10];
  logic [7:0] bp [4];
  initial begin
    prog = '{8'h30, 8'hF2, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    bp   = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    rst_n = 1'b0;
    bus.ld_start = 1'b0;
    bus.ld_base  = '0;
    bus.ld_valid = 1'b0;
    bus.ld_byte  = '0;
    bus.ld_last  = 1'b0;
    bus.f_pc     = '0;
    repeat (3) tick();
    chk("rst_ld_ready", 80'(bus.ld_ready), 80'(0));
    chk("rst_ld_done", 80'(bus.ld_done), 80'(0));
    chk("rst_ld_err", 80'(bus.ld_err), 80'(0));
    chk("rst_mem_ready", 80'(bus.mem_ready), 80'(0));
    chk("rst_imem_error", 80'(bus.imem_error), 80'(1));
    rst_n = 1'b1;
    tick();
    start(0);
    chk("load_ready", 80'(bus.ld_ready), 80'(1));
    for (int i = 0; i < 10; i++) begin
      send(prog[i], i == 9);
      if (i < 9) chk($sformatf("load_nodone_%0d", i), 80'(bus.ld_done), 80'(0));
    end
    chk("load_done", 80'(bus.ld_done), 80'(1));
    chk("load_mem_ready", 80'(bus.mem_ready), 80'(1));
    chk("load_ready_off", 80'(bus.ld_ready), 80'(0));
    chk("fetch0_byte0", 80'(bus.byte0), 80'(8'h30));
    chk("fetch0_byte19", 80'(bus.byte19), 80'(72'h00_0000_0000_0000_0AF2));
    chk("fetch0_err", 80'(bus.imem_error), 80'(0));
    tick();
    chk("load_done_pulse", 80'(bus.ld_done), 80'(0));
    chk("load_run_hold", 80'(bus.mem_ready), 80'(1));
    start(4);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("bp_gap_%0d", k), 80'(bus.ld_done), 80'(0));
      send(bp[k], k == 3);
      if (k < 3) chk($sformatf("bp_nodone_%0d", k), 80'(bus.ld_done), 80'(0));
    end
    chk("bp_done", 80'(bus.ld_done), 80'(1));
    bus.f_pc = 3;
    #1;
    chk("bp_byte0", 80'(bus.byte0), 80'(8'h00));
    chk("bp_bytes", 80'(bus.byte19[39:0]), 80'(40'h00_D4C3_B2A1));
    tick();
    chk("bp_done_pulse", 80'(bus.ld_done), 80'(0));
    start(MB - 2);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    chk("ovf_no_err", 80'(bus.ld_err), 80'(0));
    send(8'h33, 1'b0);
    chk("ovf_err", 80'(bus.ld_err), 80'(1));
    chk("ovf_ready_off", 80'(bus.ld_ready), 80'(0));
    send(8'h44, 1'b1);
    chk("ovf_no_done", 80'(bus.ld_done), 80'(0));
    chk("ovf_mem_ready", 80'(bus.mem_ready), 80'(0));
    chk("ovf_imem_error", 80'(bus.imem_error), 80'(1));
    chk("ovf_err_sticky", 80'(bus.ld_err), 80'(1));
    start(MB - 3);
    chk("ovf_err_clear", 80'(bus.ld_err), 80'(0));
    chk("ovf_reload_ready", 80'(bus.ld_ready), 80'(1));
    send(8'h55, 1'b1);
    chk("end_done", 80'(bus.ld_done), 80'(1));
    bus.f_pc = MB - 3;
    #1;
    chk("end_byte0", 80'(bus.byte0), 80'(8'h55));
    chk("end_byte19", 80'(bus.byte19), 80'(72'h2211));
    chk("end_err", 80'(bus.imem_error), 80'(0));
    bus.f_pc = MB - 1;
    #1;
    chk("last_byte0", 80'(bus.byte0), 80'(8'h22));
    chk("last_err", 80'(bus.imem_error), 80'(0));
    bus.f_pc = MB;
    #1;
    chk("top_err", 80'(bus.imem_error), 80'(1));
    bus.f_pc = '1;
    #1;
    chk("wrap_err", 80'(bus.imem_error), 80'(1));
    chk("wrap_byte19", 80'(bus.byte19), 80'(0));
    tick();
    start(0);
    for (int i = 0; i < 5; i++) send(8'h61 + 8'(i), 1'b0);
    chk("mid_ready", 80'(bus.ld_ready), 80'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 80'(bus.ld_ready), 80'(0));
    chk("mid_rst_mem_ready", 80'(bus.mem_ready), 80'(0));
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_idle_ready", 80'(bus.ld_ready), 80'(0));
    start(5);
    send(8'h77, 1'b1);
    chk("mid_done", 80'(bus.ld_done), 80'(1));
    bus.f_pc = 0;
    #1;
    chk("mid_byte0", 80'(bus.byte0), 80'(8'h61));
    chk("mid_byte19", 80'(bus.byte19), 80'(72'h00_00D4_C377_6564_6362));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
